// File: rtl/hazard_stall_ctl_pkg.sv
// Shared pipeline definitions for the decode-stage hazard/stall controller:
// opcode/funct constants, FSM state encoding, NOP encoding and small decode helpers.
package hazard_stall_ctl_pkg;

    localparam logic [5:0] OP_RTYPE    = 6'b000000;
    localparam logic [5:0] OP_BEQ      = 6'b000100;
    localparam logic [5:0] OP_BNE      = 6'b000101;
    localparam logic [5:0] OP_BLEZ     = 6'b000110;
    localparam logic [5:0] OP_BGTZ     = 6'b000111;
    localparam logic [2:0] OP_STORE_HI = 3'b101;
    localparam logic [5:0] FN_JR       = 6'b001000;

    localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_EXT   = 2'd2
    } stall_state_e;

    // Branches and jr resolve in ID, so they need their operands one stage earlier.
    function automatic logic is_branch(input logic [5:0] op, input logic [5:0] fn);
        return (op == OP_BEQ) || (op == OP_BNE) || (op == OP_BLEZ) || (op == OP_BGTZ) ||
               ((op == OP_RTYPE) && (fn == FN_JR));
    endfunction

    // rt is only read as a source by R-type, beq/bne and stores; elsewhere it is a dest or unused.
    function automatic logic uses_rt(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE) || (op[5:3] == OP_STORE_HI);
    endfunction

endpackage

// File: rtl/hazard_stall_ctl_if.sv
// Decode-stage control bundle between the pipeline (master) and the hazard/stall controller (slave).
// STALL_CYCLES exists only when HAZARD_STATS_EN is defined.
interface hazard_stall_ctl_if #(parameter int STAT_W = 16);

    logic [31:0] Instr;
    logic        RegWrite;
    logic        RegDest;
    logic        MemRead;
    logic        FWD_REQ_FREEZE;
    logic        EXT_STALL;
    logic        FREEZE_IFID;
    logic        BUBBLE_IDEXE;
    logic [1:0]  STALL_STATE;
`ifdef HAZARD_STATS_EN
    logic [STAT_W-1:0] STALL_CYCLES;
`endif

    modport master (
`ifdef HAZARD_STATS_EN
        input  STALL_CYCLES,
`endif
        output Instr, RegWrite, RegDest, MemRead, FWD_REQ_FREEZE, EXT_STALL,
        input  FREEZE_IFID, BUBBLE_IDEXE, STALL_STATE
    );

    modport slave (
`ifdef HAZARD_STATS_EN
        output STALL_CYCLES,
`endif
        input  Instr, RegWrite, RegDest, MemRead, FWD_REQ_FREEZE, EXT_STALL,
        output FREEZE_IFID, BUBBLE_IDEXE, STALL_STATE
    );

endinterface

// File: rtl/hazard_stall_ctl_load_dest_history.sv
// Two-deep history of load destination registers: lh0 = load now in EXE, lh1 = load now in MEM.
// Holds while the whole pipe is frozen; a bubble entering EXE shifts in register 0.
module load_dest_history (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       hold,
    input  logic       clear,
    input  logic [4:0] dest_in,
    output logic [4:0] lh0,
    output logic [4:0] lh1
);

    // Advance the load history alongside ID/EXE and EXE/MEM.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            lh0 <= 5'd0;
            lh1 <= 5'd0;
        end else if (!hold) begin
            lh1 <= lh0;
            lh0 <= clear ? 5'd0 : dest_in;
        end
    end

endmodule

// File: rtl/hazard_stall_ctl.sv
// Decode-stage hazard/stall controller. Detects load-use and branch/jr dependences that forwarding
// cannot cover, merges them with the forwarding unit's freeze request and external memory stalls,
// and drives the PC/IF-ID freeze and the ID/EXE bubble.
// Optional feature macro: HAZARD_STATS_EN adds the saturating STALL_CYCLES counter.
module hazard_stall_ctl
    import hazard_stall_ctl_pkg::*;
#(
    parameter int MAX_STALL = 2,
    parameter int STAT_W    = 16
) (
    input logic               CLK,
    input logic               RESET,
    hazard_stall_ctl_if.slave bus
);

    localparam int CNT_W = $clog2(MAX_STALL + 1);

    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic [4:0]       rs;
    logic [4:0]       rt;
    logic [4:0]       rd;
    logic             branch;
    logic             rt_used;
    logic [4:0]       id_dest;
    logic [4:0]       lh0;
    logic [4:0]       lh1;
    logic             hit_exe;
    logic             hit_mem;
    logic [CNT_W-1:0] need;
    logic [CNT_W-1:0] need_m1;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_dec;
    stall_state_e     state_q;
    stall_state_e     state_d;
    stall_state_e     resume_q;
    stall_state_e     resume_d;
    stall_state_e     eff_state;
    logic             freeze;
    logic             bubble;

    assign opcode  = bus.Instr[31:26];
    assign rs      = bus.Instr[25:21];
    assign rt      = bus.Instr[20:16];
    assign rd      = bus.Instr[15:11];
    assign funct   = bus.Instr[5:0];
    assign branch  = is_branch(opcode, funct);
    assign rt_used = uses_rt(opcode);
    assign id_dest = (bus.RegWrite && bus.MemRead) ? (bus.RegDest ? rd : rt) : 5'd0;

    // A match against register 0 can never be a real dependence.
    assign hit_exe = ((rs != 5'd0) && (rs == lh0)) || (rt_used && (rt != 5'd0) && (rt == lh0));
    assign hit_mem = ((rs != 5'd0) && (rs == lh1)) || (rt_used && (rt != 5'd0) && (rt == lh1));

    load_dest_history u_lh (
        .CLK     (CLK),
        .RESET   (RESET),
        .hold    (bus.EXT_STALL),
        .clear   (bubble),
        .dest_in (id_dest),
        .lh0     (lh0),
        .lh1     (lh1)
    );

    // Stall cycles the ID instruction still needs; the largest requirement wins.
    always_comb begin
        need = '0;
        if (bus.FWD_REQ_FREEZE || (hit_exe && !branch) || (hit_mem && branch)) begin
            need = CNT_W'(1);
        end
        if (hit_exe && branch) begin
            need = CNT_W'(2);
        end
    end

    assign need_m1   = (need == '0) ? '0 : need - CNT_W'(1);
    assign cnt_dec   = (cnt_q == '0) ? '0 : cnt_q - CNT_W'(1);
    assign eff_state = (state_q == ST_EXT) ? resume_q : state_q;

    // Next state and freeze/bubble; an external stall parks the hazard FSM where it is.
    always_comb begin
        state_d  = state_q;
        resume_d = resume_q;
        cnt_d    = cnt_q;
        freeze   = 1'b0;
        bubble   = 1'b0;
        if (bus.EXT_STALL) begin
            freeze   = 1'b1;
            state_d  = ST_EXT;
            resume_d = eff_state;
        end else if (eff_state == ST_STALL) begin
            freeze   = 1'b1;
            bubble   = 1'b1;
            cnt_d    = (cnt_dec > need_m1) ? cnt_dec : need_m1;
            state_d  = (cnt_d == '0) ? ST_RUN : ST_STALL;
            resume_d = state_d;
        end else begin
            state_d  = ST_RUN;
            resume_d = ST_RUN;
            if (need != '0) begin
                freeze = 1'b1;
                bubble = 1'b1;
                cnt_d  = need_m1;
                if (need_m1 != '0) begin
                    state_d = ST_STALL;
                end
                resume_d = state_d;
            end
        end
    end

    // FSM, paused-state and remaining-stall registers.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q  <= ST_RUN;
            resume_q <= ST_RUN;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            resume_q <= resume_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.FREEZE_IFID  = freeze & ~RESET;
    assign bus.BUBBLE_IDEXE = bubble & ~RESET;
    assign bus.STALL_STATE  = state_q;

`ifdef HAZARD_STATS_EN
    logic [STAT_W-1:0] stat_q;

    // Count hazard bubble cycles, sticking at all-ones.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            stat_q <= '0;
        end else if (bubble && (stat_q != '1)) begin
            stat_q <= stat_q + STAT_W'(1);
        end
    end

    assign bus.STALL_CYCLES = stat_q;
`endif

endmodule

// File: tb/tb_hazard_stall_ctl.sv
// Self-checking bench for hazard_stall_ctl: directed pipeline scenarios with literal expectations,
// then randomized instruction streams checked every cycle against a behavioural model.
// Define HAZARD_STATS_EN to also check the STALL_CYCLES counter.
module tb_hazard_stall_ctl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    hazard_stall_ctl_if #(.STAT_W(16)) bus ();

    hazard_stall_ctl #(.MAX_STALL(2), .STAT_W(16)) dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus.slave)
    );

    int   n_compared   = 0;
    int   n_mismatched = 0;
    int   m_lh0        = 0;
    int   m_lh1        = 0;
    int   m_pending    = 0;
    int   m_state      = 0;
    int   m_stats      = 0;
    logic m_freeze     = 1'b0;
    bit   chk_en       = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk_i(input int op, input int rs, input int rt, input int imm);
        return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    function automatic logic [31:0] mk_r(input int rs, input int rt, input int rd, input int fn);
        return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(fn)};
    endfunction

    // A consumer needs its value 'lat' cycles after the load leaves ID: branches read in ID (2), others in EXE (1).
    // A load already one stage further along has one fewer cycle to cover.
    function automatic int need_of(input logic [31:0] ins, input logic fwd, input int lh0, input int lh1);
        int op;
        int fn;
        int lat;
        int n;
        int srcs[2];
        bit br;
        op  = int'(ins[31:26]);
        fn  = int'(ins[5:0]);
        br  = (op >= 4 && op <= 7) || (op == 0 && fn == 8);
        lat = br ? 2 : 1;
        srcs[0] = int'(ins[25:21]);
        srcs[1] = (op == 0 || op == 4 || op == 5 || (op >= 40 && op <= 47)) ? int'(ins[20:16]) : 0;
        n = fwd ? 1 : 0;
        for (int k = 0; k < 2; k++) begin
            if (srcs[k] != 0) begin
                if (srcs[k] == lh0 && lat > n) n = lat;
                if (srcs[k] == lh1 && lat - 1 > n) n = lat - 1;
            end
        end
        return n;
    endfunction

    function automatic int model_req();
        int nd;
        nd = need_of(bus.Instr, bus.FWD_REQ_FREEZE, m_lh0, m_lh1);
        return (m_pending > nd) ? m_pending : nd;
    endfunction

    function automatic logic [31:0] rand_instr();
        int a = $urandom_range(0, 3);
        int b = $urandom_range(0, 3);
        int c = $urandom_range(0, 3);
        case ($urandom_range(0, 9))
            0, 1:    return mk_i(35, a, b, 0);
            2:       return mk_r(a, b, c, 32);
            3:       return mk_r(a, 0, 0, 8);
            4:       return mk_i(4, a, b, 0);
            5:       return mk_i(5, a, b, 0);
            6:       return mk_i(6 + $urandom_range(0, 1), a, 0, 0);
            7:       return mk_i(43, a, b, 0);
            8:       return mk_i(8, a, b, 4);
            default: return hazard_stall_ctl_pkg::NOP_INSTR;
        endcase
    endfunction

    // One pipeline cycle: drive ID contents just after the clock edge, return at the checking edge.
    task automatic applyStimulus(input logic [31:0] ins, input logic fwd, input logic ext);
        logic [5:0] op;
        logic [5:0] fn;
        @(posedge clk);
        #1;
        op = ins[31:26];
        fn = ins[5:0];
        bus.Instr          = ins;
        bus.MemRead        = (op == 6'd35);
        bus.RegDest        = (op == 6'd0);
        bus.RegWrite       = (op == 6'd35) || (op == 6'd8) || (op == 6'd0 && fn != 6'd8 && ins != 32'd0);
        bus.FWD_REQ_FREEZE = fwd;
        bus.EXT_STALL      = ext;
        @(negedge clk);
    endtask

    // Behavioural model: in-flight load dests, owed bubbles and the reported state.
    initial begin
        int req;
        int dest;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_lh0 = 0; m_lh1 = 0; m_pending = 0; m_state = 0; m_stats = 0;
            end else if (bus.EXT_STALL) begin
                m_state = 2;
            end else begin
                req  = model_req();
                dest = (bus.RegWrite && bus.MemRead) ?
                       (bus.RegDest ? int'(bus.Instr[15:11]) : int'(bus.Instr[20:16])) : 0;
                m_lh1     = m_lh0;
                m_lh0     = (req > 0) ? 0 : dest;
                m_pending = (req > 0) ? req - 1 : 0;
                m_state   = (m_pending > 0) ? 1 : 0;
                if (req > 0 && m_stats < 65535) m_stats++;
            end
        end
    end

    // Compare process: every cycle out of reset, DUT outputs against the model.
    initial begin
        int   req;
        logic eb;
        logic ef;
        forever begin
            @(negedge clk);
            if (chk_en && !rst) begin
                req = model_req();
                eb  = !bus.EXT_STALL && (req > 0);
                ef  = bus.EXT_STALL || eb;
                checkOutput("model_FREEZE_IFID", 32'(bus.FREEZE_IFID), 32'(ef));
                checkOutput("model_BUBBLE_IDEXE", 32'(bus.BUBBLE_IDEXE), 32'(eb));
                checkOutput("model_STALL_STATE", 32'(bus.STALL_STATE), 32'(m_state));
`ifdef HAZARD_STATS_EN
                checkOutput("model_STALL_CYCLES", 32'(bus.STALL_CYCLES), 32'(m_stats));
`endif
                m_freeze = ef;
            end
        end
    end

    initial begin
        logic [31:0] ins;
        int          bub_cnt;
        int          ext_bub;
        bus.Instr = '0; bus.RegWrite = 1'b0; bus.RegDest = 1'b0; bus.MemRead = 1'b0;
        bus.FWD_REQ_FREEZE = 1'b0; bus.EXT_STALL = 1'b0;
        #2 rst = 1'b1;
        #1;
        checkOutput("reset_freeze", 32'(bus.FREEZE_IFID), 0);
        checkOutput("reset_bubble", 32'(bus.BUBBLE_IDEXE), 0);
        checkOutput("reset_state", 32'(bus.STALL_STATE), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;

        // lw $5 then add $6,$5,$7: one bubble
        applyStimulus(mk_i(35, 1, 5, 0), 0, 0);
        checkOutput("s1_lw_freeze", 32'(bus.FREEZE_IFID), 0);
        applyStimulus(mk_r(5, 7, 6, 32), 0, 0);
        checkOutput("s1_use_freeze", 32'(bus.FREEZE_IFID), 1);
        checkOutput("s1_use_bubble", 32'(bus.BUBBLE_IDEXE), 1);
        applyStimulus(mk_r(5, 7, 6, 32), 0, 0);
        checkOutput("s1_after_bubble", 32'(bus.BUBBLE_IDEXE), 0);

        // lw $5 then beq $5,$0: two bubbles, state 0,1,0
        applyStimulus(mk_i(35, 1, 5, 0), 0, 0);
        applyStimulus(mk_i(4, 5, 0, 0), 0, 0);
        checkOutput("s2_br1_bubble", 32'(bus.BUBBLE_IDEXE), 1);
        checkOutput("s2_br1_state", 32'(bus.STALL_STATE), 0);
        applyStimulus(mk_i(4, 5, 0, 0), 0, 0);
        checkOutput("s2_br2_bubble", 32'(bus.BUBBLE_IDEXE), 1);
        checkOutput("s2_br2_state", 32'(bus.STALL_STATE), 1);
        applyStimulus(mk_i(4, 5, 0, 0), 0, 0);
        checkOutput("s2_br3_bubble", 32'(bus.BUBBLE_IDEXE), 0);
        checkOutput("s2_br3_state", 32'(bus.STALL_STATE), 0);
        applyStimulus(mk_i(35, 1, 5, 0), 0, 0);
        applyStimulus(hazard_stall_ctl_pkg::NOP_INSTR, 0, 0);
        applyStimulus(mk_r(5, 7, 6, 32), 0, 0);
        checkOutput("s2_gap_no_stall", 32'(bus.BUBBLE_IDEXE), 0);

        // load to $0 then use $0; lw $8 then addi $8,$1 (rt not a source)
        applyStimulus(mk_i(35, 1, 0, 0), 0, 0);
        applyStimulus(mk_r(0, 0, 6, 32), 0, 0);
        checkOutput("s3_reg0_no_stall", 32'(bus.BUBBLE_IDEXE), 0);
        applyStimulus(mk_i(35, 1, 8, 0), 0, 0);
        applyStimulus(mk_i(8, 1, 8, 4), 0, 0);
        checkOutput("s3_addi_no_stall", 32'(bus.BUBBLE_IDEXE), 0);

        // forwarding-unit freeze alone, then coincident with a 2-cycle hazard
        applyStimulus(hazard_stall_ctl_pkg::NOP_INSTR, 1, 0);
        checkOutput("s4_fwd_bubble", 32'(bus.BUBBLE_IDEXE), 1);
        applyStimulus(hazard_stall_ctl_pkg::NOP_INSTR, 0, 0);
        checkOutput("s4_fwd_done", 32'(bus.BUBBLE_IDEXE), 0);
        applyStimulus(mk_i(35, 1, 5, 0), 0, 0);
        bub_cnt = 0;
        applyStimulus(mk_i(4, 5, 0, 0), 1, 0);
        bub_cnt += int'(bus.BUBBLE_IDEXE);
        repeat (3) begin
            applyStimulus(mk_i(4, 5, 0, 0), 0, 0);
            bub_cnt += int'(bus.BUBBLE_IDEXE);
        end
        checkOutput("s4_total_bubbles", 32'(bub_cnt), 2);

        // external stall for 3 cycles in the middle of a 2-cycle hazard stall
        applyStimulus(mk_i(35, 1, 5, 0), 0, 0);
        bub_cnt = 0;
        ext_bub = 0;
        applyStimulus(mk_i(4, 5, 0, 0), 0, 0);
        bub_cnt += int'(bus.BUBBLE_IDEXE);
        repeat (3) begin
            applyStimulus(mk_i(4, 5, 0, 0), 0, 1);
            ext_bub += int'(bus.BUBBLE_IDEXE);
            checkOutput("s5_ext_freeze", 32'(bus.FREEZE_IFID), 1);
        end
        applyStimulus(mk_i(4, 5, 0, 0), 0, 0);
        bub_cnt += int'(bus.BUBBLE_IDEXE);
        checkOutput("s5_resume_state", 32'(bus.STALL_STATE), 2);
        repeat (2) begin
            applyStimulus(mk_i(4, 5, 0, 0), 0, 0);
            bub_cnt += int'(bus.BUBBLE_IDEXE);
        end
        checkOutput("s5_ext_bubbles", 32'(ext_bub), 0);
        checkOutput("s5_total_bubbles", 32'(bub_cnt), 2);

        // reset in the middle of a stall
        applyStimulus(mk_i(35, 1, 5, 0), 0, 0);
        applyStimulus(mk_i(4, 5, 0, 0), 0, 0);
        applyStimulus(mk_i(4, 5, 0, 0), 0, 0);
        checkOutput("s6_pre_reset_bubble", 32'(bus.BUBBLE_IDEXE), 1);
        #2 rst = 1'b1;
        #1;
        checkOutput("s6_reset_freeze", 32'(bus.FREEZE_IFID), 0);
        checkOutput("s6_reset_bubble", 32'(bus.BUBBLE_IDEXE), 0);
        checkOutput("s6_reset_state", 32'(bus.STALL_STATE), 0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(mk_i(4, 5, 0, 0), 0, 0);
        checkOutput("s6_no_pending", 32'(bus.BUBBLE_IDEXE), 0);

`ifdef HAZARD_STATS_EN
        repeat (65540) applyStimulus(hazard_stall_ctl_pkg::NOP_INSTR, 1, 0);
        checkOutput("stats_saturate", 32'(bus.STALL_CYCLES), 32'h0000_FFFF);
        applyStimulus(hazard_stall_ctl_pkg::NOP_INSTR, 0, 0);
        #2 rst = 1'b1;
        #1;
        checkOutput("stats_reset", 32'(bus.STALL_CYCLES), 0);
        @(negedge clk);
        rst = 1'b0;
`endif

        // randomized instruction stream; ID holds its instruction while frozen
        ins = hazard_stall_ctl_pkg::NOP_INSTR;
        for (int i = 0; i < 1500; i++) begin
            if (!m_freeze) ins = rand_instr();
            applyStimulus(ins, ($urandom_range(0, 9) == 0), ($urandom_range(0, 6) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
